systolic_skew_buffer: RTL and testbench

Parametrised, bidirectional skew/deskew stage between the Unified Buffer and the systolic array. In skew mode, lane r of each accepted vector is delayed by r cycles so that data enters the array diagonally. In deskew mode, lane r is delayed by ROWS-1-r so that diagonal array outputs are realigned into row vectors. A three-state controller handles the rest: it accepts vectors with a valid/ready handshake, inserts zero bubbles on idle cycles, drains the pipeline after the last vector, and flags the final element.

---
 rtl/systolic_skew_buffer_if.sv | 40 ++++
 rtl/systolic_skew_buffer.sv | 174 +++++++++++++++++
 tb/tb_systolic_skew_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_skew_buffer_if.sv
// Bundles the vector handshake and the per-lane output bus of
// systolic_skew_buffer so upstream and downstream logic see one port.
//
// Parameters
//   ROWS    lane count (>= 2)
//   DATA_W  bits per lane element
//
// Signals
//   in_valid / in_ready  vector handshake from the Unified Buffer side
//   in_data [ROWS-1:0]   one element per lane
//   in_last              marks the final vector of a burst
//   out_data [ROWS-1:0]  per-lane skewed/deskewed element, 0 on bubbles
//   out_valid            per-lane slot valid
//   out_last             final element of the burst leaves the longest lane
//
// Modports
//   master  drives the input side, observes the outputs
//   slave   the skew buffer itself
interface systolic_skew_buffer_if #(
  parameter int ROWS   = 16,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] in_data  [ROWS-1:0];
  logic [DATA_W-1:0] out_data [ROWS-1:0];
  logic [ROWS-1:0]   out_valid;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Skew/deskew stage between the Unified Buffer and the systolic array.
// Skew mode delays lane r by r cycles so vectors enter the array on a
// diagonal; deskew mode delays lane r by ROWS-1-r to realign diagonal array
// outputs into row vectors. A three-state controller (IDLE/STREAM/DRAIN)
// accepts vectors, injects zero bubbles on idle cycles, drains the lanes
// after the last vector and flags the final element.
//
// Configuration macro: SKEW_BUF_DESKEW_EN
//   defined   - deskew input and mode latch exist; every lane is a ROWS-1
//               deep delay line with a mode-selected tap
//   undefined - mode is fixed to skew, lane r holds exactly r registers
//
// Ports
//   clk     sole clock, rising edge
//   rst     asynchronous, active-low reset
//   deskew  mode select (0 skew, 1 deskew), captured on the first accept
//   stall   freezes lanes, counter and state; blocks accepts
//   busy    controller is not IDLE
//   bus     systolic_skew_buffer_if.slave (handshake + lane outputs)
module systolic_skew_buffer #(
  parameter int ROWS   = 16,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  deskew,
  input  logic                  stall,
  output logic                  busy,
  systolic_skew_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inReady;
  logic             accept;
  logic             outLast;
  logic             effMode;

  assign accept = bus.in_valid & inReady;

  // State register: burst controller state plus the drain countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: a last vector starts a ROWS-1 cycle drain so the
  // longest lane can empty; stall freezes everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      case (state_q)
        IDLE, STREAM: begin
          if (accept && bus.in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(ROWS - 1);
          end else if (accept) begin
            state_d = STREAM;
          end
        end
        DRAIN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: ready is withheld while draining, stalled or in reset so
  // nothing reaches the combinational lane; out_last depends only on state.
  always_comb begin
    inReady = rst & (state_q != DRAIN) & ~stall;
    busy    = (state_q != IDLE);
    outLast = (state_q == DRAIN) && (cnt_q == CNT_W'(1));
  end

  assign bus.in_ready = inReady;
  assign bus.out_last = outLast;

`ifdef SKEW_BUF_DESKEW_EN
  logic mode_q;

  // Mode latch: written only by the first accept of a burst, so toggling
  // deskew mid-burst has no effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= 1'b0;
    end else if (accept && (state_q == IDLE)) begin
      mode_q <= deskew;
    end
  end

  // The opening accept must already steer its zero-delay lane by the new mode.
  assign effMode = (state_q == IDLE) ? deskew : mode_q;
`else
  logic unusedDeskew;
  assign unusedDeskew = deskew;
  assign effMode      = 1'b0;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : gLane
`ifdef SKEW_BUF_DESKEW_EN
    localparam int DEPTH = ROWS - 1;
`else
    localparam int DEPTH = r;
`endif
    logic [DATA_W-1:0]            injData;
    logic [DEPTH:0][DATA_W-1:0]   tapData;
    logic [DEPTH:0]               tapValid;
    logic                         unusedTaps;

    assign injData = accept ? bus.in_data[r] : '0;

    if (DEPTH == 0) begin : gNoReg
      assign tapData  = injData;
      assign tapValid = accept;
    end else begin : gReg
      logic [DEPTH-1:0][DATA_W-1:0] data_q;
      logic [DEPTH-1:0]             valid_q;

      // Delay line: every non-stalled cycle shifts in the accepted element
      // or a {0,0} bubble.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_q  <= '0;
          valid_q <= '0;
        end else if (!stall) begin
          data_q[0]  <= injData;
          valid_q[0] <= accept;
          for (int j = 1; j < DEPTH; j++) begin
            data_q[j]  <= data_q[j-1];
            valid_q[j] <= valid_q[j-1];
          end
        end
      end

      // Tap 0 is the combinational path, tap j the output of stage j-1.
      assign tapData  = {data_q, injData};
      assign tapValid = {valid_q, accept};
    end

`ifdef SKEW_BUF_DESKEW_EN
    assign bus.out_data[r]  = effMode ? tapData[ROWS-1-r]  : tapData[r];
    assign bus.out_valid[r] = effMode ? tapValid[ROWS-1-r] : tapValid[r];
`else
    assign bus.out_data[r]  = tapData[r];
    assign bus.out_valid[r] = tapValid[r];
`endif

    // Taps not chosen by either mode exist only to feed later stages.
    assign unusedTaps = ^{tapData, tapValid, effMode};
  end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Self-checking bench for systolic_skew_buffer (ROWS=4, DATA_W=8).
// A reference model records every non-stalled cycle's injected vector in a
// history ring; lane r at a given non-stalled tick shows the entry injected
// d(r) ticks earlier. Directed scenarios are followed by random traffic.
module tb_systolic_skew_buffer;
  localparam int ROWS   = 4;
  localparam int DATA_W = 8;
  localparam int RING   = 64;
`ifdef SKEW_BUF_DESKEW_EN
  localparam bit DESKEW_BUILT = 1'b1;
`else
  localparam bit DESKEW_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic deskew;
  logic stall;
  logic busy;

  systolic_skew_buffer_if #(.ROWS(ROWS), .DATA_W(DATA_W)) bus ();

  systolic_skew_buffer #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .deskew (deskew),
    .stall  (stall),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: tick counts non-stalled cycles.
  int  tick;
  int  lastTick;
  bit  inBurst;
  bit  draining;
  bit  burstMode;
  logic [ROWS*DATA_W-1:0] ringData  [RING];
  bit                     ringValid [RING];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < RING; i++) begin
      ringValid[i] = 1'b0;
      ringData[i]  = '0;
    end
    inBurst   = 1'b0;
    draining  = 1'b0;
    burstMode = 1'b0;
    tick      = RING;
    lastTick  = 0;
  endtask

  // One clock cycle: drive at the falling edge, compare against the model,
  // then advance the model across the coming rising edge.
  task automatic applyStimulus(input bit v, input bit l, input bit dsk, input bit stl,
                               input logic [ROWS*DATA_W-1:0] vec);
    bit idle, readyExp, accept, modeNow, lastExp, ev;
    int d, idx;
    logic [DATA_W-1:0] ed;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_last  = l;
    deskew       = dsk;
    stall        = stl;
    for (int r = 0; r < ROWS; r++) bus.in_data[r] = vec[r*DATA_W +: DATA_W];
    #1;
    idle     = !inBurst && !draining;
    readyExp = !draining && !stl;
    accept   = v && readyExp;
    modeNow  = idle ? (dsk && DESKEW_BUILT) : burstMode;
    lastExp  = draining && (tick == lastTick + ROWS - 1);
    for (int r = 0; r < ROWS; r++) begin
      d = modeNow ? (ROWS - 1 - r) : r;
      if (d == 0) begin
        ev = accept;
        ed = accept ? vec[r*DATA_W +: DATA_W] : '0;
      end else begin
        idx = (tick - d) % RING;
        ev  = ringValid[idx];
        ed  = ringData[idx][r*DATA_W +: DATA_W];
      end
      checkOutput($sformatf("lane%0d valid", r), bus.out_valid[r], ev);
      checkOutput($sformatf("lane%0d data", r), bus.out_data[r], ed);
    end
    checkOutput("in_ready", bus.in_ready, readyExp);
    checkOutput("out_last", bus.out_last, lastExp);
    checkOutput("busy", busy, !idle);
    if (!stl) begin
      ringValid[tick % RING] = accept;
      ringData[tick % RING]  = accept ? vec : '0;
      if (lastExp) begin
        draining = 1'b0;
      end else if (accept) begin
        if (idle) burstMode = dsk && DESKEW_BUILT;
        if (l) begin
          draining = 1'b1;
          inBurst  = 1'b0;
          lastTick = tick;
        end else begin
          inBurst = 1'b1;
        end
      end
      tick++;
    end
  endtask

  logic [ROWS*DATA_W-1:0] vecA, vecB, vecR;

  initial begin
    vecA = {8'h44, 8'h33, 8'h22, 8'h11};
    vecB = {8'h14, 8'h13, 8'h12, 8'h11};
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    deskew       = 1'b0;
    stall        = 1'b0;
    for (int r = 0; r < ROWS; r++) bus.in_data[r] = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", bus.out_valid, '0);
    checkOutput("reset out_data", {bus.out_data[3], bus.out_data[2], bus.out_data[1], bus.out_data[0]}, '0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset out_last", bus.out_last, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("ready after reset", bus.in_ready, 1'b1);

    // Single-vector skew burst.
    applyStimulus(1, 1, 0, 0, vecA);
    checkOutput("t1 lane0@0", bus.out_data[0], 8'h11);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t1 lane1@1", bus.out_data[1], 8'h22);
    checkOutput("t1 ready@1", bus.in_ready, 1'b0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t1 lane2@2", bus.out_data[2], 8'h33);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t1 lane3@3", bus.out_data[3], 8'h44);
    checkOutput("t1 last@3", bus.out_last, 1'b1);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t1 ready@4", bus.in_ready, 1'b1);

    // Deskew burst with deskew toggled while draining.
    applyStimulus(1, 1, 1, 0, vecA);
    checkOutput("t2 valid@0", bus.out_valid, DESKEW_BUILT ? 4'b1000 : 4'b0001);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t2 valid@1", bus.out_valid, DESKEW_BUILT ? 4'b0100 : 4'b0010);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t2 valid@3", bus.out_valid, DESKEW_BUILT ? 4'b0001 : 4'b1000);
    checkOutput("t2 data@3", DESKEW_BUILT ? bus.out_data[0] : bus.out_data[3], DESKEW_BUILT ? 8'h11 : 8'h44);
    checkOutput("t2 last@3", bus.out_last, 1'b1);

    // Burst with a one-cycle gap.
    applyStimulus(1, 0, 0, 0, vecA);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t3 lane1@1", bus.out_data[1], 8'h22);
    applyStimulus(1, 1, 0, 0, vecB);
    checkOutput("t3 lane1 bubble valid@2", bus.out_valid[1], 1'b0);
    checkOutput("t3 lane1 bubble data@2", bus.out_data[1], 8'h00);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t3 lane1@3", bus.out_data[1], 8'h12);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t3 last@5", bus.out_last, 1'b1);
    applyStimulus(0, 0, 0, 0, '0);

    // Stall during the drain of a single-vector skew burst.
    applyStimulus(1, 1, 0, 0, vecA);
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(1, 0, 0, 1, vecB);
    checkOutput("t4 lane2 frozen@3", bus.out_data[2], 8'h33);
    checkOutput("t4 ready stalled@3", bus.in_ready, 1'b0);
    applyStimulus(0, 0, 0, 1, '0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t4 last not@5", bus.out_last, 1'b0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("t4 lane3@6", bus.out_data[3], 8'h44);
    checkOutput("t4 last@6", bus.out_last, 1'b1);
    applyStimulus(0, 0, 0, 0, '0);

    // Asynchronous reset in the middle of a drain.
    applyStimulus(1, 1, 0, 0, vecA);
    applyStimulus(0, 0, 0, 0, '0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("t5 out_valid in reset", bus.out_valid, '0);
    checkOutput("t5 out_data in reset", {bus.out_data[3], bus.out_data[2], bus.out_data[1], bus.out_data[0]}, '0);
    checkOutput("t5 busy in reset", busy, 1'b0);
    checkOutput("t5 last in reset", bus.out_last, 1'b0);
    @(negedge clk);
    checkOutput("t5 last held reset", bus.out_last, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("t5 ready after release", bus.in_ready, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, '0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      vecR = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, vecR);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
